// File: rtl/id_exe_forward_reg.sv
// ID/EXE pipeline register with load-use / RAW stall generation and
// registered forwarding selects for the EXE-stage operand muxes.
module id_exe_forward_reg #(
  parameter bit FORWARD_EN = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        flush,
  input  logic        id_valid,
  input  logic [4:0]  id_src1,
  input  logic [4:0]  id_src2,
  input  logic        id_uses_src2,
  input  logic [31:0] id_val1,
  input  logic [31:0] id_val2,
  input  logic [31:0] id_imm,
  input  logic        id_imm_sel,
  input  logic [4:0]  id_dest,
  input  logic        id_wb_en,
  input  logic        id_mem_read,
  input  logic        id_mem_write,
  input  logic [4:0]  mem_dest,
  input  logic        mem_wb_en,
  output logic        exe_valid,
  output logic        exe_imm_sel,
  output logic        exe_wb_en,
  output logic        exe_mem_read,
  output logic        exe_mem_write,
  output logic [31:0] exe_val1,
  output logic [31:0] exe_val2,
  output logic [31:0] exe_imm,
  output logic [4:0]  exe_dest,
  output logic [1:0]  exe_fwd_sel1,
  output logic [1:0]  exe_fwd_sel2,
  output logic        stall,
  output logic [15:0] stall_count
);

  localparam int unsigned REG_W  = 5;
  localparam int unsigned SEL_W  = 2;
  localparam int unsigned CNT_W  = 16;
  localparam logic [SEL_W-1:0] SEL_RF  = 2'b00;
  localparam logic [SEL_W-1:0] SEL_MEM = 2'b01;
  localparam logic [SEL_W-1:0] SEL_WB  = 2'b10;

  logic             src1_exe;
  logic             src2_exe;
  logic             src1_mem;
  logic             src2_mem;
  logic             hazard;
  logic             bubble;
  logic [SEL_W-1:0] sel1_next;
  logic [SEL_W-1:0] sel2_next;

  // Register 0 never matches; src2 only counts when it is actually read.
  always_comb begin
    src1_exe = (id_src1 != REG_W'(0)) && exe_valid && exe_wb_en && (id_src1 == exe_dest);
    src2_exe = id_uses_src2 && (id_src2 != REG_W'(0)) && exe_valid && exe_wb_en &&
               (id_src2 == exe_dest);
    src1_mem = (id_src1 != REG_W'(0)) && mem_wb_en && (id_src1 == mem_dest);
    src2_mem = id_uses_src2 && (id_src2 != REG_W'(0)) && mem_wb_en && (id_src2 == mem_dest);
  end

  // With forwarding only a load in EXE cannot be bypassed; without it every RAW waits.
  always_comb begin
    hazard    = 1'b0;
    sel1_next = SEL_RF;
    sel2_next = SEL_RF;
    if (FORWARD_EN) begin
      hazard = exe_mem_read && (src1_exe || src2_exe);
      if (src1_exe)      sel1_next = SEL_MEM;
      else if (src1_mem) sel1_next = SEL_WB;
      if (src2_exe)      sel2_next = SEL_MEM;
      else if (src2_mem) sel2_next = SEL_WB;
    end else begin
      hazard = src1_exe || src2_exe || src1_mem || src2_mem;
    end
  end

  // Gated by rst so nothing is asserted while the pipeline is held in reset.
  assign stall  = rst && id_valid && hazard && !flush;
  assign bubble = flush || stall;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      exe_valid     <= 1'b0;
      exe_imm_sel   <= 1'b0;
      exe_wb_en     <= 1'b0;
      exe_mem_read  <= 1'b0;
      exe_mem_write <= 1'b0;
      exe_val1      <= '0;
      exe_val2      <= '0;
      exe_imm       <= '0;
      exe_dest      <= '0;
      exe_fwd_sel1  <= SEL_RF;
      exe_fwd_sel2  <= SEL_RF;
    end else if (bubble) begin
      exe_valid     <= 1'b0;
      exe_wb_en     <= 1'b0;
      exe_mem_read  <= 1'b0;
      exe_mem_write <= 1'b0;
      exe_fwd_sel1  <= SEL_RF;
      exe_fwd_sel2  <= SEL_RF;
    end else begin
      exe_valid     <= id_valid;
      exe_imm_sel   <= id_imm_sel && id_valid;
      exe_wb_en     <= id_wb_en && id_valid;
      exe_mem_read  <= id_mem_read && id_valid;
      exe_mem_write <= id_mem_write && id_valid;
      exe_val1      <= id_val1;
      exe_val2      <= id_val2;
      exe_imm       <= id_imm;
      exe_dest      <= id_dest;
      exe_fwd_sel1  <= sel1_next;
      exe_fwd_sel2  <= sel2_next;
    end
  end

  // Saturating stall-cycle counter.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_count <= '0;
    end else if (stall && (stall_count != {CNT_W{1'b1}})) begin
      stall_count <= stall_count + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_id_exe_forward_reg.sv
// Directed bench for id_exe_forward_reg: forwarding and non-forwarding instances.
module tb_id_exe_forward_reg;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush, id_valid, id_uses_src2, id_imm_sel, id_wb_en, id_mem_read, id_mem_write;
  logic [4:0]  id_src1, id_src2, id_dest, mem_dest;
  logic        mem_wb_en;
  logic [31:0] id_val1, id_val2, id_imm;

  logic        f_valid, f_imm_sel, f_wb, f_mr, f_mw, f_stall;
  logic [31:0] f_v1, f_v2, f_imm;
  logic [4:0]  f_dest;
  logic [1:0]  f_s1, f_s2;
  logic [15:0] f_cnt;

  logic        n_valid, n_imm_sel, n_wb, n_mr, n_mw, n_stall;
  logic [31:0] n_v1, n_v2, n_imm;
  logic [4:0]  n_dest;
  logic [1:0]  n_s1, n_s2;
  logic [15:0] n_cnt;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  id_exe_forward_reg #(.FORWARD_EN(1'b1)) u_fw (
    .clk(clk), .rst(rst), .flush(flush), .id_valid(id_valid),
    .id_src1(id_src1), .id_src2(id_src2), .id_uses_src2(id_uses_src2),
    .id_val1(id_val1), .id_val2(id_val2), .id_imm(id_imm), .id_imm_sel(id_imm_sel),
    .id_dest(id_dest), .id_wb_en(id_wb_en), .id_mem_read(id_mem_read),
    .id_mem_write(id_mem_write), .mem_dest(mem_dest), .mem_wb_en(mem_wb_en),
    .exe_valid(f_valid), .exe_imm_sel(f_imm_sel), .exe_wb_en(f_wb),
    .exe_mem_read(f_mr), .exe_mem_write(f_mw), .exe_val1(f_v1), .exe_val2(f_v2),
    .exe_imm(f_imm), .exe_dest(f_dest), .exe_fwd_sel1(f_s1), .exe_fwd_sel2(f_s2),
    .stall(f_stall), .stall_count(f_cnt));

  id_exe_forward_reg #(.FORWARD_EN(1'b0)) u_nf (
    .clk(clk), .rst(rst), .flush(flush), .id_valid(id_valid),
    .id_src1(id_src1), .id_src2(id_src2), .id_uses_src2(id_uses_src2),
    .id_val1(id_val1), .id_val2(id_val2), .id_imm(id_imm), .id_imm_sel(id_imm_sel),
    .id_dest(id_dest), .id_wb_en(id_wb_en), .id_mem_read(id_mem_read),
    .id_mem_write(id_mem_write), .mem_dest(mem_dest), .mem_wb_en(mem_wb_en),
    .exe_valid(n_valid), .exe_imm_sel(n_imm_sel), .exe_wb_en(n_wb),
    .exe_mem_read(n_mr), .exe_mem_write(n_mw), .exe_val1(n_v1), .exe_val2(n_v2),
    .exe_imm(n_imm), .exe_dest(n_dest), .exe_fwd_sel1(n_s1), .exe_fwd_sel2(n_s2),
    .stall(n_stall), .stall_count(n_cnt));

  typedef struct {
    logic        valid;
    logic [4:0]  src1;
    logic [4:0]  src2;
    logic        uses2;
    logic [4:0]  dest;
    logic        wb;
    logic        mr;
    logic [4:0]  mdest;
    logic        mwb;
    logic        fl;
    logic [31:0] val1;
    logic        e_stall;
    logic        e_valid;
    logic [1:0]  e_sel1;
    logic [1:0]  e_sel2;
    logic        e_wb;
    logic        e_mr;
    logic [15:0] e_cnt;
    logic [31:0] e_val1;
  } vec_t;

  vec_t vecs[12];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [4:0] s1, input logic [4:0] s2,
                       input logic u2, input logic [4:0] d, input logic wb, input logic mr,
                       input logic [4:0] md, input logic mwb, input logic fl,
                       input logic [31:0] v1);
    id_valid = v; id_src1 = s1; id_src2 = s2; id_uses_src2 = u2; id_dest = d;
    id_wb_en = wb; id_mem_read = mr; mem_dest = md; mem_wb_en = mwb; flush = fl;
    id_val1 = v1; id_val2 = ~v1; id_imm = 32'h0000_0040; id_imm_sel = 1'b0;
    id_mem_write = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin
    // valid src1 src2 u2 dest wb mr mdest mwb fl val1 | stall valid sel1 sel2 wb mr cnt val1
    vecs[0]  = '{1, 3, 0, 0, 5, 1, 0, 0, 0, 0, 32'h100, 0, 1, 2'b00, 2'b00, 1, 0, 16'd0, 32'h100};
    vecs[1]  = '{1, 5, 5, 1, 7, 1, 0, 0, 0, 0, 32'h101, 0, 1, 2'b01, 2'b01, 1, 0, 16'd0, 32'h101};
    vecs[2]  = '{1, 7, 7, 1, 8, 1, 0, 7, 1, 0, 32'h102, 0, 1, 2'b01, 2'b01, 1, 0, 16'd0, 32'h102};
    vecs[3]  = '{1, 7, 7, 1, 0, 0, 0, 7, 1, 0, 32'h103, 0, 1, 2'b10, 2'b10, 0, 0, 16'd0, 32'h103};
    vecs[4]  = '{1, 0, 0, 1, 0, 1, 0, 0, 1, 0, 32'h104, 0, 1, 2'b00, 2'b00, 1, 0, 16'd0, 32'h104};
    vecs[5]  = '{1, 1, 2, 0, 9, 1, 1, 0, 0, 0, 32'h105, 0, 1, 2'b00, 2'b00, 1, 1, 16'd0, 32'h105};
    vecs[6]  = '{1, 1, 9, 0, 9, 1, 1, 9, 1, 0, 32'h106, 0, 1, 2'b00, 2'b00, 1, 1, 16'd0, 32'h106};
    vecs[7]  = '{1, 1, 9, 1, 11, 1, 0, 9, 1, 0, 32'h107, 1, 0, 2'b00, 2'b00, 0, 0, 16'd1, 32'h106};
    vecs[8]  = '{1, 1, 9, 1, 11, 1, 0, 9, 1, 0, 32'h108, 0, 1, 2'b00, 2'b10, 1, 0, 16'd1, 32'h108};
    vecs[9]  = '{1, 0, 0, 0, 12, 1, 1, 11, 1, 0, 32'h109, 0, 1, 2'b00, 2'b00, 1, 1, 16'd1, 32'h109};
    vecs[10] = '{1, 12, 0, 0, 13, 1, 0, 12, 1, 1, 32'h10A, 0, 0, 2'b00, 2'b00, 0, 0, 16'd1, 32'h109};
    vecs[11] = '{0, 3, 0, 0, 3, 1, 0, 0, 0, 0, 32'h10B, 0, 0, 2'b00, 2'b00, 0, 0, 16'd1, 32'h10B};

    // Reset with arbitrary inputs: every output of both instances must be zero.
    rst = 1'b0;
    drive(1'b1, 5'd4, 5'd4, 1'b1, 5'd4, 1'b1, 1'b1, 5'd4, 1'b1, 1'b0, $urandom);
    repeat (2) @(posedge clk);
    #1;
    chk("rst_fw_valid", 32'(f_valid), 0);
    chk("rst_fw_stall", 32'(f_stall), 0);
    chk("rst_fw_cnt", 32'(f_cnt), 0);
    chk("rst_fw_v1", f_v1, 0);
    chk("rst_fw_sel", 32'({f_s1, f_s2, f_wb, f_mr, f_mw, f_imm_sel}), 0);
    chk("rst_nf_stall", 32'(n_stall), 0);
    chk("rst_nf_valid", 32'(n_valid), 0);
    @(negedge clk);
    rst = 1'b1;

    // Forwarding instance: one vector per cycle, continuous pipeline history.
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      drive(vecs[i].valid, vecs[i].src1, vecs[i].src2, vecs[i].uses2, vecs[i].dest,
            vecs[i].wb, vecs[i].mr, vecs[i].mdest, vecs[i].mwb, vecs[i].fl, vecs[i].val1);
      #1;
      chk($sformatf("v%0d_stall", i), 32'(f_stall), 32'(vecs[i].e_stall));
      @(posedge clk);
      #1;
      chk($sformatf("v%0d_valid", i), 32'(f_valid), 32'(vecs[i].e_valid));
      chk($sformatf("v%0d_sel1", i), 32'(f_s1), 32'(vecs[i].e_sel1));
      chk($sformatf("v%0d_sel2", i), 32'(f_s2), 32'(vecs[i].e_sel2));
      chk($sformatf("v%0d_wb", i), 32'(f_wb), 32'(vecs[i].e_wb));
      chk($sformatf("v%0d_mr", i), 32'(f_mr), 32'(vecs[i].e_mr));
      chk($sformatf("v%0d_cnt", i), 32'(f_cnt), 32'(vecs[i].e_cnt));
      chk($sformatf("v%0d_val1", i), f_v1, vecs[i].e_val1);
    end

    // Reset asserted in the middle of a load-use stall.
    @(negedge clk);
    drive(1'b1, 5'd0, 5'd0, 1'b0, 5'd14, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0, 32'h200);
    @(negedge clk);
    drive(1'b1, 5'd14, 5'd0, 1'b0, 5'd15, 1'b1, 1'b0, 5'd14, 1'b1, 1'b0, 32'h201);
    #1;
    chk("mid_stall_before", 32'(f_stall), 1);
    #1;
    rst = 1'b0;
    #1;
    chk("mid_stall_rst_stall", 32'(f_stall), 0);
    chk("mid_stall_rst_valid", 32'(f_valid), 0);
    chk("mid_stall_rst_cnt", 32'(f_cnt), 0);
    @(negedge clk);
    rst = 1'b1;

    // Non-forwarding instance: producer dest 4, consumer src1 4.
    do_reset();
    drive(1'b1, 5'd0, 5'd0, 1'b0, 5'd4, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0, 32'h300);
    @(posedge clk);
    #1;
    chk("nf_prod_valid", 32'(n_valid), 1);
    @(negedge clk);
    drive(1'b1, 5'd4, 5'd0, 1'b0, 5'd5, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0, 32'h301);
    #1;
    chk("nf_stall0", 32'(n_stall), 1);
    @(posedge clk);
    #1;
    chk("nf_bubble0", 32'(n_valid), 0);
    @(negedge clk);
    mem_dest = 5'd4; mem_wb_en = 1'b1;
    #1;
    chk("nf_stall1", 32'(n_stall), 1);
    @(posedge clk);
    #1;
    chk("nf_cnt2", 32'(n_cnt), 2);
    @(negedge clk);
    mem_dest = 5'd0; mem_wb_en = 1'b0;
    #1;
    chk("nf_stall2", 32'(n_stall), 0);
    @(posedge clk);
    #1;
    chk("nf_capture_valid", 32'(n_valid), 1);
    chk("nf_capture_sel1", 32'(n_s1), 0);
    chk("nf_capture_v1", n_v1, 32'h301);

    // Hold a MEM-stage RAW stall long enough to saturate the counter.
    @(negedge clk);
    drive(1'b1, 5'd6, 5'd0, 1'b0, 5'd7, 1'b1, 1'b0, 5'd6, 1'b1, 1'b0, 32'h302);
    repeat (65540) @(posedge clk);
    #1;
    chk("nf_sat", 32'(n_cnt), 32'hFFFF);
    chk("nf_sat_stall", 32'(n_stall), 1);
    @(posedge clk);
    #1;
    chk("nf_sat_hold", 32'(n_cnt), 32'hFFFF);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
